// File: rtl/scale_tile_pingpong.sv
// Double-buffered dequant scale feeder.
// Two tile banks act as a ping-pong pair: one drains one LANES_NUM-wide beat
// per step_i while the other (the shadow) is free to take the next tile, so
// back-to-back tiles stream with no bubble. Broadcast tiles replicate
// element 0 onto every lane of every beat.
module scale_tile_pingpong #(
    parameter int LANES_NUM = 16,
    parameter int FP_MANT_W = 23,
    parameter int FP_EXP_W  = 8,
    parameter int ELEMS     = 256,
    localparam int BEATS    = ELEMS / LANES_NUM,
    localparam int BCNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           tile_valid_i,
    output logic                           tile_ready_o,
    input  logic                           tile_mode_i,
    input  logic [FP_MANT_W*ELEMS-1:0]     tile_mant_i,
    input  logic [FP_EXP_W*ELEMS-1:0]      tile_exp_i,
    input  logic                           step_i,
    output logic                           lanes_valid_o,
    output logic [LANES_NUM*FP_MANT_W-1:0] cur_mant_lanes_o,
    output logic [LANES_NUM*FP_EXP_W-1:0]  cur_exp_lanes_o,
    output logic [BCNT_W-1:0]              beat_idx_o,
    output logic                           last_beat_o,
    output logic                           tile_done_o,
    output logic                           underrun_o
);

    localparam int EIDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    // Bank storage, one element per entry
    logic [FP_MANT_W-1:0] mant_q [2][ELEMS];
    logic [FP_EXP_W-1:0]  exp_q  [2][ELEMS];
    logic [1:0]           mode_q;

    // Control state
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              rd_sel;
    logic [BCNT_W-1:0] beat_cnt;
    logic              tile_done_q;
    logic              underrun_q;

    logic accept;
    logic wr_sel;
    logic consume;
    logic at_last;
    logic last_consume;

    // Element feeding lane j of beat b; broadcast tiles always read element 0
    function automatic logic [EIDX_W-1:0] elem_of(input logic [BCNT_W-1:0] b,
                                                  input int j,
                                                  input logic bcast);
        if (bcast)
            return '0;
        return EIDX_W'(int'(b) * LANES_NUM + j);
    endfunction

    // The shadow bank can only be full when the active one is, so a free
    // bank exists exactly when not both are full.
    assign tile_ready_o  = !(full[0] && full[1]);
    assign accept        = tile_valid_i && tile_ready_o;
    assign wr_sel        = full[rd_sel] ? ~rd_sel : rd_sel;
    assign lanes_valid_o = full[rd_sel];
    assign consume       = step_i && lanes_valid_o;
    assign at_last       = (beat_cnt == BCNT_W'(BEATS - 1));
    assign last_consume  = consume && at_last;

    assign beat_idx_o  = beat_cnt;
    assign last_beat_o = lanes_valid_o && at_last;
    assign tile_done_o = tile_done_q;
    assign underrun_o  = underrun_q;

    // Next bank-occupancy: drain the active bank, fill the target bank
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
        full_next = full;
        if (last_consume)
            full_next[rd_sel] = 1'b0;
        if (accept)
            full_next[wr_sel] = 1'b1;
    end

    // Capture an accepted tile into its target bank
    // NOTE: bank contents carry no reset; full[] alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (accept && !flush_i) begin
            mode_q[wr_sel] <= tile_mode_i;
            for (int k = 0; k < ELEMS; k++) begin
                mant_q[wr_sel][k] <= tile_mant_i[k*FP_MANT_W +: FP_MANT_W];
                exp_q[wr_sel][k]  <= tile_exp_i[k*FP_EXP_W +: FP_EXP_W];
            end
        end
    end

    // Bank ownership, beat counting, done pulse and sticky underrun
    // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= '0;
            rd_sel      <= 1'b0;
            beat_cnt    <= '0;
            tile_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else if (flush_i) begin
            full        <= '0;
            rd_sel      <= 1'b0;
            beat_cnt    <= '0;
            tile_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            full        <= full_next;
            tile_done_q <= last_consume;
            if (step_i && !lanes_valid_o)
                underrun_q <= 1'b1;
            if (consume) begin
                if (at_last) begin
                    beat_cnt <= '0;
                    rd_sel   <= ~rd_sel;
                end else begin
                    beat_cnt <= beat_cnt + BCNT_W'(1);
                end
            end
        end
    end

    // Present the current beat of the active bank, zero when nothing is valid
    always_comb begin
        cur_mant_lanes_o = '0;
        cur_exp_lanes_o  = '0;
        if (lanes_valid_o) begin
            for (int j = 0; j < LANES_NUM; j++) begin
                cur_mant_lanes_o[j*FP_MANT_W +: FP_MANT_W] =
                    mant_q[rd_sel][elem_of(beat_cnt, j, mode_q[rd_sel])];
                cur_exp_lanes_o[j*FP_EXP_W +: FP_EXP_W] =
                    exp_q[rd_sel][elem_of(beat_cnt, j, mode_q[rd_sel])];
            end
        end
    end

endmodule

// File: tb/tb_scale_tile_pingpong.sv
// Randomised self-checking bench for scale_tile_pingpong. A queue-of-tiles
// model tracks which tile is being served and which beat of it; one compare
// process checks every DUT output against it on each falling edge, and the
// directed scenarios add literal expectations.
module tb_scale_tile_pingpong;

    localparam int LANES = 16;
    localparam int MW    = 23;
    localparam int EW    = 8;
    localparam int ELEMS = 256;
    localparam int BEATS = ELEMS / LANES;
    localparam int BW    = 4;

    typedef logic [511:0] wide_t;

    typedef struct {
        logic                  mode;
        logic [MW*ELEMS-1:0]   mant;
        logic [EW*ELEMS-1:0]   ex;
    } tile_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  tile_valid = 1'b0;
    logic                  tile_ready;
    logic                  tile_mode = 1'b0;
    logic [MW*ELEMS-1:0]   tile_mant = '0;
    logic [EW*ELEMS-1:0]   tile_exp = '0;
    logic                  step = 1'b0;
    logic                  lanes_valid;
    logic [LANES*MW-1:0]   cur_mant;
    logic [LANES*EW-1:0]   cur_exp;
    logic [BW-1:0]         beat_idx;
    logic                  last_beat;
    logic                  tile_done;
    logic                  underrun;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    // Model state
    tile_t q[$];
    int    mbeat   = 0;
    bit    m_done  = 1'b0;
    bit    m_under = 1'b0;

    logic [LANES*MW-1:0] e_mant;
    logic [LANES*EW-1:0] e_exp;

    scale_tile_pingpong dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .tile_valid_i     (tile_valid),
        .tile_ready_o     (tile_ready),
        .tile_mode_i      (tile_mode),
        .tile_mant_i      (tile_mant),
        .tile_exp_i       (tile_exp),
        .step_i           (step),
        .lanes_valid_o    (lanes_valid),
        .cur_mant_lanes_o (cur_mant),
        .cur_exp_lanes_o  (cur_exp),
        .beat_idx_o       (beat_idx),
        .last_beat_o      (last_beat),
        .tile_done_o      (tile_done),
        .underrun_o       (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic gen_random();
        for (int k = 0; k < ELEMS; k++) begin
            tile_mant[k*MW +: MW] = MW'($urandom);
            tile_exp[k*EW +: EW]  = EW'($urandom);
        end
    endtask

    task automatic gen_ramp();
        for (int k = 0; k < ELEMS; k++) begin
            tile_mant[k*MW +: MW] = MW'(k);
            tile_exp[k*EW +: EW]  = EW'(k);
        end
    endtask

    // Model: a tile queue (at most two entries), the beat being served in the
    // head tile, the done flag and the sticky underrun flag.
    always @(posedge clk or posedge rst) begin
        bit v, r;
        if (rst) begin
            q.delete();
            mbeat = 0; m_done = 1'b0; m_under = 1'b0;
        end else if (flush) begin
            q.delete();
            mbeat = 0; m_done = 1'b0; m_under = 1'b0;
        end else begin
            v = (q.size() > 0);
            r = (q.size() < 2);
            m_done = 1'b0;
            if (step) begin
                if (v) begin
                    mbeat++;
                    if (mbeat == BEATS) begin
                        void'(q.pop_front());
                        mbeat  = 0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_under = 1'b1;
                end
            end
            if (tile_valid && r)
                q.push_back('{mode: tile_mode, mant: tile_mant, ex: tile_exp});
        end
    end

    // Compare every DUT output against the model away from the active edge
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            e_mant = '0;
            e_exp  = '0;
            if (q.size() > 0) begin
                for (int j = 0; j < LANES; j++) begin
                    int idx;
                    idx = q[0].mode ? 0 : mbeat * LANES + j;
                    e_mant[j*MW +: MW] = q[0].mant[idx*MW +: MW];
                    e_exp[j*EW +: EW]  = q[0].ex[idx*EW +: EW];
                end
            end
            check("ready",     wide_t'(tile_ready),  wide_t'(q.size() < 2));
            check("valid",     wide_t'(lanes_valid), wide_t'(q.size() > 0));
            check("mant",      wide_t'(cur_mant),    wide_t'(e_mant));
            check("exp",       wide_t'(cur_exp),     wide_t'(e_exp));
            check("beat_idx",  wide_t'(beat_idx),    wide_t'(q.size() > 0 ? mbeat : 0));
            check("last_beat", wide_t'(last_beat),   wide_t'(q.size() > 0 && mbeat == BEATS - 1));
            check("tile_done", wide_t'(tile_done),   wide_t'(m_done));
            check("underrun",  wide_t'(underrun),    wide_t'(m_under));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", wide_t'(tile_ready),  wide_t'(1));
        check("rst_valid", wide_t'(lanes_valid), wide_t'(0));
        check("rst_mant",  wide_t'(cur_mant),    wide_t'(0));
        check("rst_exp",   wide_t'(cur_exp),     wide_t'(0));
        check("rst_idx",   wide_t'(beat_idx),    wide_t'(0));

        // Step with nothing valid raises underrun
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("underrun_set", wide_t'(underrun), wide_t'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("underrun_flush", wide_t'(underrun), wide_t'(0));

        // Per-element ramp tile, continuous step
        tile_valid = 1'b1; tile_mode = 1'b0; gen_ramp();
        @(negedge clk);
        tile_valid = 1'b0; step = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) @(negedge clk);
            check("ramp_mant", wide_t'(cur_mant[(b%LANES)*MW +: MW]), wide_t'(16*b + b%LANES));
            check("ramp_exp",  wide_t'(cur_exp[0 +: EW]),             wide_t'(16*b));
            check("ramp_last", wide_t'(last_beat),                    wide_t'(b == BEATS - 1));
        end
        @(negedge clk);
        step = 1'b0;
        check("ramp_done",      wide_t'(tile_done),   wide_t'(1));
        check("ramp_valid_off", wide_t'(lanes_valid), wide_t'(0));
        @(negedge clk);
        check("ramp_done_pulse", wide_t'(tile_done), wide_t'(0));

        // Two tiles back to back, no valid gap over 32 beats
        tile_valid = 1'b1; gen_random();
        @(negedge clk);
        gen_random(); step = 1'b1;
        for (int i = 0; i < 2*BEATS; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) tile_valid = 1'b0;
            check("b2b_valid", wide_t'(lanes_valid), wide_t'(1));
            if (i == 1 || i == 15) check("b2b_ready_low",  wide_t'(tile_ready), wide_t'(0));
            if (i == 16)           check("b2b_ready_rise", wide_t'(tile_ready), wide_t'(1));
        end
        @(negedge clk);
        step = 1'b0;
        check("b2b_drained", wide_t'(lanes_valid), wide_t'(0));

        // Broadcast tile
        tile_valid = 1'b1; tile_mode = 1'b1; gen_random();
        tile_mant[0 +: MW] = 23'h400000;
        tile_exp[0 +: EW]  = 8'h7F;
        @(negedge clk);
        tile_valid = 1'b0; tile_mode = 1'b0; step = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) @(negedge clk);
            check("bcast_mant", wide_t'(cur_mant[b*MW +: MW]), wide_t'(23'h400000));
            check("bcast_exp",  wide_t'(cur_exp[b*EW +: EW]),  wide_t'(8'h7F));
        end
        @(negedge clk);
        step = 1'b0;

        // Accept coincident with last beat of the active tile
        tile_valid = 1'b1; gen_ramp();
        @(negedge clk);
        tile_valid = 1'b0; step = 1'b1;
        for (int b = 1; b < BEATS; b++) @(negedge clk);
        check("coinc_last", wide_t'(last_beat), wide_t'(1));
        tile_valid = 1'b1; gen_random();
        tile_mant[0 +: MW] = 23'h12345;
        @(negedge clk);
        tile_valid = 1'b0; step = 1'b0;
        check("coinc_valid", wide_t'(lanes_valid),       wide_t'(1));
        check("coinc_idx",   wide_t'(beat_idx),          wide_t'(0));
        check("coinc_mant",  wide_t'(cur_mant[0 +: MW]), wide_t'(23'h12345));
        step = 1'b1;
        repeat (BEATS) @(negedge clk);
        step = 1'b0;

        // Mid-tile flush with shadow full and a tile on offer
        step = 1'b1;
        @(negedge clk);
        step = 1'b0; tile_valid = 1'b1; gen_random();
        @(negedge clk);
        gen_random();
        @(negedge clk);
        tile_valid = 1'b0; step = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_flush_ready", wide_t'(tile_ready), wide_t'(0));
        flush = 1'b1; tile_valid = 1'b1; gen_random();
        @(negedge clk);
        flush = 1'b0; tile_valid = 1'b0; step = 1'b0;
        check("flush_valid",    wide_t'(lanes_valid), wide_t'(0));
        check("flush_ready",    wide_t'(tile_ready),  wide_t'(1));
        check("flush_underrun", wide_t'(underrun),    wide_t'(0));
        repeat (3) @(negedge clk);
        check("flush_dropped", wide_t'(lanes_valid), wide_t'(0));

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flush      = ($urandom_range(99) == 0);
            tile_valid = ($urandom_range(99) < 35);
            if (tile_valid) begin
                tile_mode = 1'($urandom_range(1));
                gen_random();
            end
            step = ($urandom_range(99) < 80);
        end
        @(negedge clk);
        flush = 1'b1; tile_valid = 1'b0; step = 1'b0;
        @(negedge clk);
        flush = 1'b0;

        // Asynchronous reset between edges while a tile is mid-drain
        tile_valid = 1'b1; tile_mode = 1'b0; gen_random();
        @(negedge clk);
        tile_valid = 1'b0; step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        check("pre_rst_idx", wide_t'(beat_idx), wide_t'(3));
        #2 rst = 1'b1;
        #1;
        check("arst_ready", wide_t'(tile_ready),  wide_t'(1));
        check("arst_valid", wide_t'(lanes_valid), wide_t'(0));
        check("arst_mant",  wide_t'(cur_mant),    wide_t'(0));
        check("arst_idx",   wide_t'(beat_idx),    wide_t'(0));
        check("arst_last",  wide_t'(last_beat),   wide_t'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
